// File: rtl/sad_pair_engine.sv
// Sum-of-absolute-differences engine for a pair of candidate positions.
// Accumulates |frame_a - window| and |frame_b - window| over one reference
// window in a 2-stage pipeline, then presents both SADs with the candidate's
// address tag and A-to-B stride through a valid/ready handshake.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start                      begin a new SAD pair (sampled in IDLE only)
//   tag_in, tag_stride_in      candidate tag / B offset, captured on start
//   pixel_valid, pixel_ready   pixel-triple handshake
//   frame_pixel_a/b            frame pixels for candidates A and B
//   window_pixel               reference window pixel
//   sad_valid, sad_ready       result handshake
//   busy                       high from accepted start to result handshake
//   sad_value_small_a/b        saturated SADs
//   sad_tag, sad_tag_stride    captured tag and stride
module sad_pair_engine #(
  parameter int unsigned WINDOW_PIXELS = 16,
  parameter int unsigned SAD_W         = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [31:0]       tag_in,
  input  logic [9:0]        tag_stride_in,
  input  logic              pixel_valid,
  input  logic [7:0]        frame_pixel_a,
  input  logic [7:0]        frame_pixel_b,
  input  logic [7:0]        window_pixel,
  input  logic              sad_ready,
  output logic              busy,
  output logic              pixel_ready,
  output logic              sad_valid,
  output logic [SAD_W-1:0]  sad_value_small_a,
  output logic [SAD_W-1:0]  sad_value_small_b,
  output logic [31:0]       sad_tag,
  output logic [9:0]        sad_tag_stride
);

  localparam int unsigned CNT_W = $clog2(WINDOW_PIXELS + 1);
  // One spare bit so an overflowing sum is visible before clamping.
  localparam int unsigned ACC_W = SAD_W + 1;
  localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {SAD_W{1'b1}}};
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW_PIXELS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, EMIT} state_t;

  state_t           state;
  logic [CNT_W-1:0] pix_cnt;
  logic             s1_valid;
  logic [7:0]       d1_a, d1_b;
  logic [ACC_W-1:0] acc_a, acc_b;

  logic             accept_c;
  logic [ACC_W-1:0] sum_a_c, sum_b_c, sat_a_c, sat_b_c;

  function automatic logic [7:0] abs_diff(input logic [7:0] x, input logic [7:0] y);
    return (x >= y) ? (x - y) : (y - x);
  endfunction

  // Pixel acceptance and saturating stage-2 sums.
  always_comb begin
    accept_c = (state == ACCUM) && pixel_valid && pixel_ready;
    sum_a_c  = acc_a + ACC_W'(d1_a);
    sum_b_c  = acc_b + ACC_W'(d1_b);
    sat_a_c  = (sum_a_c > SAT_MAX) ? SAT_MAX : sum_a_c;
    sat_b_c  = (sum_b_c > SAT_MAX) ? SAT_MAX : sum_b_c;
  end

  // Control FSM, pipeline and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      pix_cnt           <= '0;
      s1_valid          <= 1'b0;
      d1_a              <= '0;
      d1_b              <= '0;
      acc_a             <= '0;
      acc_b             <= '0;
      busy              <= 1'b0;
      pixel_ready       <= 1'b0;
      sad_valid         <= 1'b0;
      sad_value_small_a <= '0;
      sad_value_small_b <= '0;
      sad_tag           <= '0;
      sad_tag_stride    <= '0;
    end else begin
      // Stage 1: absolute differences of the accepted triple.
      s1_valid <= accept_c;
      if (accept_c) begin
        d1_a <= abs_diff(frame_pixel_a, window_pixel);
        d1_b <= abs_diff(frame_pixel_b, window_pixel);
      end
      // Stage 2: accumulate.
      if (s1_valid) begin
        acc_a <= sat_a_c;
        acc_b <= sat_b_c;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state          <= ACCUM;
            busy           <= 1'b1;
            pixel_ready    <= 1'b1;
            pix_cnt        <= '0;
            acc_a          <= '0;
            acc_b          <= '0;
            sad_tag        <= tag_in;
            sad_tag_stride <= tag_stride_in;
          end
        end
        ACCUM: begin
          if (accept_c) begin
            pix_cnt <= pix_cnt + CNT_W'(1);
            if (pix_cnt == LAST_IDX) pixel_ready <= 1'b0;
          end
          // pixel_ready low here means the last pixel sits in stage 1 and
          // retires on this edge.
          if (!pixel_ready) state <= DRAIN;
        end
        DRAIN: begin
          state             <= EMIT;
          sad_valid         <= 1'b1;
          sad_value_small_a <= acc_a[SAD_W-1:0];
          sad_value_small_b <= acc_b[SAD_W-1:0];
        end
        EMIT: begin
          if (sad_ready) begin
            state     <= IDLE;
            sad_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sad_pair_engine.sv
// Randomized self-checking bench for sad_pair_engine: a 16-pixel instance
// and a 64-pixel instance (for saturation) share the pixel and ready inputs.
module tb_sad_pair_engine;

  localparam int SAD_W = 13;
  localparam int SAT   = 8191;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start_s, start_b, pixel_valid, sad_ready, sel_big;
  logic [31:0] tag_in;
  logic [9:0]  tag_stride_in;
  logic [7:0]  frame_pixel_a, frame_pixel_b, window_pixel;

  logic busy_s, pr_s, v_s, busy_b, pr_b, v_b;
  logic [SAD_W-1:0] a_s, b_s, a_b, b_b;
  logic [31:0] t_s, t_b;
  logic [9:0]  st_s, st_b;

  logic o_busy, o_pr, o_valid;
  logic [SAD_W-1:0] o_a, o_b;
  logic [31:0] o_tag;
  logic [9:0]  o_stride;
  assign o_busy   = sel_big ? busy_b : busy_s;
  assign o_pr     = sel_big ? pr_b   : pr_s;
  assign o_valid  = sel_big ? v_b    : v_s;
  assign o_a      = sel_big ? a_b    : a_s;
  assign o_b      = sel_big ? b_b    : b_s;
  assign o_tag    = sel_big ? t_b    : t_s;
  assign o_stride = sel_big ? st_b   : st_s;

  sad_pair_engine #(.WINDOW_PIXELS(16), .SAD_W(SAD_W)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .tag_in(tag_in),
    .tag_stride_in(tag_stride_in), .pixel_valid(pixel_valid),
    .frame_pixel_a(frame_pixel_a), .frame_pixel_b(frame_pixel_b),
    .window_pixel(window_pixel), .sad_ready(sad_ready), .busy(busy_s),
    .pixel_ready(pr_s), .sad_valid(v_s), .sad_value_small_a(a_s),
    .sad_value_small_b(b_s), .sad_tag(t_s), .sad_tag_stride(st_s));

  sad_pair_engine #(.WINDOW_PIXELS(64), .SAD_W(SAD_W)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .tag_in(tag_in),
    .tag_stride_in(tag_stride_in), .pixel_valid(pixel_valid),
    .frame_pixel_a(frame_pixel_a), .frame_pixel_b(frame_pixel_b),
    .window_pixel(window_pixel), .sad_ready(sad_ready), .busy(busy_b),
    .pixel_ready(pr_b), .sad_valid(v_b), .sad_value_small_a(a_b),
    .sad_value_small_b(b_b), .sad_tag(t_b), .sad_tag_stride(st_b));

  int checks = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // kind: 0 fixed (10,20,15), 1 random, 2 saturating (255,0,0), 3 A=B=W
  task automatic pick(input int kind, output logic [7:0] pa, output logic [7:0] pb,
                      output logic [7:0] pw);
    case (kind)
      0: begin pa = 8'd10; pb = 8'd20; pw = 8'd15; end
      1: begin pa = 8'($urandom); pb = 8'($urandom); pw = 8'($urandom); end
      2: begin pa = 8'd255; pb = 8'd0; pw = 8'd0; end
      default: begin pw = 8'($urandom); pa = pw; pb = pw; end
    endcase
  endtask

  function automatic int absd(input int x, input int y);
    return (x > y) ? x - y : y - x;
  endfunction

  task automatic run_pair(input bit big, input logic [31:0] tag, input logic [9:0] stride,
                          input int kind, input bit gapped, input bit early_ready,
                          input int hold, input bit restart_in_hold);
    int n, exp_a, exp_b, accepted, lat;
    bit v;
    logic [7:0] pa, pb, pw;
    n = big ? 64 : 16;
    exp_a = 0; exp_b = 0; accepted = 0;
    sel_big = big;
    sad_ready = early_ready;
    check("idle_busy", 64'(o_busy), 64'd0);
    tag_in = tag; tag_stride_in = stride;
    start_s = !big; start_b = big;
    @(negedge clk);
    start_s = 1'b0; start_b = 1'b0;
    tag_in = $urandom; tag_stride_in = 10'($urandom);
    check("busy_after_start", 64'(o_busy), 64'd1);
    for (int c = 0; accepted < n && c < 1000; c++) begin
      check("pixel_ready_accum", 64'(o_pr), 64'd1);
      v = gapped ? (c % 2 == 0) : 1'b1;
      pick(kind, pa, pb, pw);
      pixel_valid = v; frame_pixel_a = pa; frame_pixel_b = pb; window_pixel = pw;
      @(negedge clk);
      if (v) begin
        accepted++;
        exp_a += absd(int'(pa), int'(pw));
        exp_b += absd(int'(pb), int'(pw));
      end
    end
    if (exp_a > SAT) exp_a = SAT;
    if (exp_b > SAT) exp_b = SAT;
    check("pixel_ready_done", 64'(o_pr), 64'd0);
    lat = 0;
    while (o_valid !== 1'b1 && lat < 20) begin
      // Pixels offered after the window is full must be ignored.
      pixel_valid = gapped;
      frame_pixel_a = 8'($urandom); frame_pixel_b = 8'($urandom); window_pixel = 8'($urandom);
      @(negedge clk);
      lat++;
    end
    pixel_valid = 1'b0;
    check("latency", 64'(lat), 64'd2);
    check("sad_a", 64'(o_a), 64'(exp_a));
    check("sad_b", 64'(o_b), 64'(exp_b));
    check("sad_tag", 64'(o_tag), 64'(tag));
    check("sad_stride", 64'(o_stride), 64'(stride));
    check("busy_emit", 64'(o_busy), 64'd1);
    for (int h = 0; h < hold; h++) begin
      if (big) start_b = restart_in_hold && (h == 1);
      else     start_s = restart_in_hold && (h == 1);
      @(negedge clk);
      check("hold_valid", 64'(o_valid), 64'd1);
      check("hold_busy", 64'(o_busy), 64'd1);
      check("hold_a", 64'(o_a), 64'(exp_a));
      check("hold_b", 64'(o_b), 64'(exp_b));
      check("hold_tag", 64'(o_tag), 64'(tag));
    end
    sad_ready = 1'b1;
    if (big) start_b = restart_in_hold; else start_s = restart_in_hold;
    @(negedge clk);
    sad_ready = 1'b0; start_s = 1'b0; start_b = 1'b0;
    check("post_hs_valid", 64'(o_valid), 64'd0);
    check("post_hs_busy", 64'(o_busy), 64'd0);
    check("persist_a", 64'(o_a), 64'(exp_a));
    check("persist_tag", 64'(o_tag), 64'(tag));
    if (restart_in_hold) begin
      @(negedge clk);
      check("start_at_hs_ignored", 64'(o_busy), 64'd0);
    end
  endtask

  initial begin
    logic [7:0] pa, pb, pw;
    rst_n = 1'b0; start_s = 1'b0; start_b = 1'b0; pixel_valid = 1'b0; sad_ready = 1'b0;
    sel_big = 1'b0; tag_in = '0; tag_stride_in = '0;
    frame_pixel_a = '0; frame_pixel_b = '0; window_pixel = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'({busy_s, busy_b}), 64'd0);
    check("rst_valid", 64'({v_s, v_b}), 64'd0);
    check("rst_pready", 64'({pr_s, pr_b}), 64'd0);
    check("rst_sads", 64'({a_s, b_s, a_b, b_b}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_pair(1'b0, 32'h1000, 10'd4, 0, 1'b0, 1'b0, 0, 1'b0);      // basic
    run_pair(1'b0, 32'h1000, 10'd4, 0, 1'b1, 1'b0, 0, 1'b0);      // gapped
    run_pair(1'b0, $urandom, 10'($urandom), 1, 1'b0, 1'b0, 5, 1'b1); // backpressure
    run_pair(1'b1, $urandom, 10'($urandom), 2, 1'b0, 1'b0, 0, 1'b0); // saturation
    run_pair(1'b0, 32'h2000, 10'd9, 1, 1'b0, 1'b0, 0, 1'b0);      // back-to-back
    for (int r = 0; r < 4; r++)
      run_pair(1'b0, $urandom, 10'($urandom), ($urandom_range(0, 1) == 0) ? 1 : 3,
               1'($urandom), 1'($urandom), 0, 1'b0);
    run_pair(1'b1, $urandom, 10'($urandom), 1, 1'b1, 1'b1, 0, 1'b0);

    // Reset in the middle of accumulation.
    sel_big = 1'b0;
    tag_in = 32'hDEAD_BEEF; tag_stride_in = 10'd33; start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    for (int i = 0; i < 7; i++) begin
      pick(1, pa, pb, pw);
      pixel_valid = 1'b1; frame_pixel_a = pa; frame_pixel_b = pb; window_pixel = pw;
      @(negedge clk);
    end
    pixel_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy_s), 64'd0);
    check("midrst_pready", 64'(pr_s), 64'd0);
    check("midrst_valid", 64'(v_s), 64'd0);
    check("midrst_sads", 64'({a_s, b_s}), 64'd0);
    check("midrst_tag", 64'({t_s, st_s}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_stale_valid", 64'(v_s), 64'd0);
    end
    run_pair(1'b0, 32'h0000_0042, 10'd1, 3, 1'b0, 1'b0, 0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sad_pair_engine.md
Name: sad_pair_engine

Overview:
- Producer side of the SAD min-tracking datapath.
- Accumulates the sum of absolute differences for two candidate frame positions (A and B) against one reference window, in parallel.
- Emits the two 13-bit SAD values with the candidate's 32-bit address tag and 10-bit B-offset.
- Downstream min/tag tracker picks the smaller of the two and records the matching tag.

Parameters:
- WINDOW_PIXELS, 16, pixels per SAD window; legal range 1..1024.
- SAD_W, 13, SAD output width; accumulators saturate at 2^SAD_W-1.

Ports:
- Clk  input  1  system clock, rising edge
- Reset  input  1  asynchronous, active-low reset
- Start  input  1  begin a new SAD pair; sampled only in IDLE
- TagIn  input  32  address tag of candidate A; captured on accepted Start
- TagStrideIn  input  10  address offset from A to B; captured on accepted Start
- PixelValid  input  1  pixel triple valid this cycle
- FramePixel_A  input  8  frame pixel for candidate A
- FramePixel_B  input  8  frame pixel for candidate B
- WindowPixel  input  8  reference window pixel
- SADReady  input  1  consumer accepts the result
- Busy  output  1  high from accepted Start until result handshake completes
- PixelReady  output  1  high in ACCUM while pixel count < WINDOW_PIXELS
- SADValid  output  1  result valid; held until SADReady
- SAD_value_small_A  output  13  SAD of candidate A
- SAD_value_small_B  output  13  SAD of candidate B
- SAD_Tag  output  32  captured TagIn
- SAD_TagStride  output  10  captured TagStrideIn

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; accumulators, pixel counter and pipeline valid cleared. Reset mid-operation discards partial sums; no SADValid follows.
- FSM states: IDLE, ACCUM, DRAIN, EMIT.
- IDLE to ACCUM on Start=1. In the same cycle: capture TagIn and TagStrideIn, clear accumulators and counter, raise Busy.
- ACCUM:
  - A pixel is accepted when PixelValid & PixelReady.
  - Stage 1 registers |FramePixel_A-WindowPixel| and |FramePixel_B-WindowPixel|, each 8-bit unsigned.
  - Stage 2 adds those into the A/B accumulators, saturating at 8191.
  - Counter increments per accepted pixel. PixelReady drops the cycle after the WINDOW_PIXELS-th accept.
  - PixelValid while PixelReady=0 is ignored.
- ACCUM to DRAIN after the last pixel is accepted. DRAIN is 1 cycle, letting stage 2 retire.
- DRAIN to EMIT: SADValid=1. A, B, tag and stride are stable while SADValid=1.
- Latency: SADValid rises 2 cycles after the clock edge that accepts the last pixel.
- EMIT: hold all outputs until SADReady=1 at a clock edge; then go to IDLE and drop SADValid and Busy on that edge.
- SADReady=1 before SADValid has no effect.
- Start while not IDLE is ignored. Start in the cycle EMIT completes is also ignored; it must be re-presented in IDLE.
- Output values persist after the handshake until the next result; only SADValid qualifies them.
- Equal A and B are emitted as-is; tie-breaking belongs to the consumer.
- Accumulator width is SAD_W+1 internally so saturation is detected; output is clamped to SAD_W bits.
- Counter width is ceil(log2(WINDOW_PIXELS+1)).

Test Plan:
- Basic: Start, TagIn=0x1000, stride=4; 16 pixels with A=10, B=20, W=15 every cycle -> SADValid 2 cycles after the 16th accept; A=80, B=80, SAD_Tag=0x1000, SAD_TagStride=4.
- Gapped input: same data with PixelValid toggling 1/0 -> identical results; PixelReady=0 after the 16th accept; extra PixelValid pulses do not change the sums.
- Backpressure: hold SADReady=0 for 5 cycles after SADValid -> outputs stable, Busy=1; SADReady=1 -> SADValid=0 and Busy=0 next edge. A second Start during the hold is ignored.
- Saturation: WINDOW_PIXELS=64; A=255, B=0, W=0 -> A=8191 (clamped), B=0.
- Reset mid-run: drop Reset after 7 pixels -> all outputs 0 immediately. Release, then a fresh 16-pixel run with A=W=B -> A=0, B=0, and no stale SADValid.
- Back-to-back: Start asserted in the cycle after the handshake with new tag 0x2000 -> second result carries 0x2000 and sums independent of the first run.
